// File: rtl/hamming_receptor_pkg.sv
// Shared definitions for the Hamming(7,4) serial link: FSM states, code positions and line levels.
// Code bit index n holds c(n+1); c1 is the first bit on the wire.
package hamming_receptor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DECODE
    } rx_state_e;

    localparam int FRAME_BITS = 7;

    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D1 = 2;
    localparam int P4 = 3;
    localparam int D2 = 4;
    localparam int D3 = 5;
    localparam int D4 = 6;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/hamming_receptor_decoder.sv
// Combinational Hamming(7,4) decoder: syndrome, single-bit correction, nibble extraction.
// Zero latency; no flow control.
module hamming74_decoder
    import hamming_receptor_pkg::*;
(
    input  logic [FRAME_BITS-1:0] code_i,
    output logic [3:0]            data_o,
    output logic [2:0]            syndrome_o
);

    logic [2:0]            syn;
    logic [FRAME_BITS-1:0] fixed;

    always_comb begin
        syn[0] = code_i[P1] ^ code_i[D1] ^ code_i[D2] ^ code_i[D4];
        syn[1] = code_i[P2] ^ code_i[D1] ^ code_i[D3] ^ code_i[D4];
        syn[2] = code_i[P4] ^ code_i[D2] ^ code_i[D3] ^ code_i[D4];

        // A nonzero syndrome is the 1-based position of the flipped bit.
        fixed = code_i;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (syn == 3'(i + 1)) begin
                fixed[i] = ~code_i[i];
            end
        end

        data_o     = {fixed[D4], fixed[D3], fixed[D2], fixed[D1]};
        syndrome_o = syn;
    end

endmodule

// File: rtl/hamming_receptor.sv
// Serial Hamming(7,4) receiver: mid-bit sampling, single-error correction, one-cycle strobes.
// data_valid one cycle after the stop-bit sample; no backpressure, downstream must accept every strobe.
module hamming_receptor
    import hamming_receptor_pkg::*;
#(
    parameter int CLK_PER_BIT = 10
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] data,
    output logic       data_valid,
    output logic       corrected,
    output logic       frame_err,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(FRAME_BITS - 1);

    rx_state_e             state_q;
    logic                  rx_meta_q;
    logic                  rx_sync_q;
    logic                  line_high_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            idx_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [3:0]            data_q;
    logic                  data_valid_q;
    logic                  corrected_q;
    logic                  frame_err_q;

    logic [3:0]            dec_data;
    logic [2:0]            dec_syn;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= LINE_IDLE;
            rx_sync_q <= LINE_IDLE;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    hamming74_decoder u_decoder (
        .code_i     (shift_q),
        .data_o     (dec_data),
        .syndrome_o (dec_syn)
    );

    // line_high_q arms start detection: a start needs the line seen high since the last frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            line_high_q  <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            corrected_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (rx_sync_q == LINE_IDLE) begin
                line_high_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (line_high_q && rx_sync_q == LINE_START) begin
                        line_high_q <= 1'b0;
                        state_q     <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        state_q <= (rx_sync_q == LINE_START) ? ST_DATA : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_sync_q;
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            state_q <= ST_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rx_sync_q == LINE_STOP) begin
                            state_q <= ST_DECODE;
                        end else begin
                            frame_err_q <= 1'b1;
                            line_high_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DECODE: begin
                    data_q       <= dec_data;
                    corrected_q  <= (dec_syn != 3'd0);
                    data_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign corrected  = corrected_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
